// File: rtl/mem_sim_pkg.sv
// Shared definitions for the latency-modelling memory: FSM encoding and counter width.
package mem_sim_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_sim_array.sv
// Storage array: one synchronous write port, one asynchronous read port, no reset.
module mem_sim_array #(
  parameter int logsize = 4,
  parameter int width   = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [logsize-1:0] waddr,
  input  logic [width-1:0]   wdata,
  input  logic [logsize-1:0] raddr,
  output logic [width-1:0]   rdata
);

  logic [width-1:0] mem_q [2**logsize];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_sim_latency.sv
// Memory model with a fixed access latency and a power-up clear sweep.
// Handshake: a request is taken on a rising edge with doit=1 and busy=0; doit while busy=1 is dropped.
module mem_sim_latency
  import mem_sim_pkg::*;
#(
  parameter int               logsize     = 4,
  parameter int               width       = 8,
  parameter int               latency     = 3,
  parameter logic [width-1:0] clear_value = '0
) (
  input  logic               clk,
  input  logic               init,
  input  logic [logsize-1:0] addr,
  input  logic [width-1:0]   wdata,
  input  logic               wselect,
  input  logic               doit,
  output logic               busy,
  output logic               rvalid,
  output logic [width-1:0]   rdata,
  output logic [1:0]         dbg_state
);

  localparam logic [logsize-1:0] PTR_MAX = '1;
  localparam logic [CNT_W-1:0]   LAT_M1  = CNT_W'(latency - 1);

  state_t             state_q, state_d;
  logic [logsize-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [logsize-1:0] cap_addr_q, cap_addr_d;
  logic [width-1:0]   cap_wdata_q, cap_wdata_d;
  logic               cap_wsel_q, cap_wsel_d;
  logic [width-1:0]   rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;

  logic               mem_we;
  logic [logsize-1:0] mem_waddr;
  logic [width-1:0]   mem_wdata;
  logic [width-1:0]   mem_rdata;

  mem_sim_array #(
    .logsize (logsize),
    .width   (width)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (cap_addr_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    cap_wsel_d  = cap_wsel_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cap_addr_q;
    mem_wdata   = cap_wdata_q;
    busy        = 1'b1;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = clear_value;
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Completion cycle: finish the pending op and reopen for a new request.
          busy    = 1'b0;
          state_d = ST_IDLE;
          if (cap_wsel_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (doit && !busy) begin
      state_d     = ST_WAIT;
      cnt_d       = LAT_M1;
      cap_addr_d  = addr;
      cap_wdata_d = wdata;
      cap_wsel_d  = wselect;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      cnt_q       <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_wsel_q  <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
      cap_wsel_q  <= cap_wsel_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_sim_latency.sv
// Scoreboard bench: instance 0 runs latency 3, instance 1 runs latency 1, both clear to 8'h5A.
module tb_mem_sim_latency;
  import mem_sim_pkg::*;

  localparam logic [7:0] CV = 8'h5A;

  logic       clk = 1'b0;
  logic       init    [2];
  logic [3:0] addr    [2];
  logic [7:0] wdata   [2];
  logic       wselect [2];
  logic       doit    [2];
  logic       busy    [2];
  logic       rvalid  [2];
  logic [7:0] rdata   [2];
  logic [1:0] dbg     [2];

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] mem_m [2][16];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         expt_q0[$];
  int         expt_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_sim_latency #(.logsize(4), .width(8), .latency(3), .clear_value(CV)) dut0 (
    .clk(clk), .init(init[0]), .addr(addr[0]), .wdata(wdata[0]), .wselect(wselect[0]),
    .doit(doit[0]), .busy(busy[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .dbg_state(dbg[0])
  );

  mem_sim_latency #(.logsize(4), .width(8), .latency(1), .clear_value(CV)) dut1 (
    .clk(clk), .init(init[1]), .addr(addr[1]), .wdata(wdata[1]), .wselect(wselect[1]),
    .doit(doit[1]), .busy(busy[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .dbg_state(dbg[1])
  );

  function automatic int lat_of(int u);
    return (u == 0) ? 3 : 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(int u, logic [7:0] d, int t);
    if (u == 0) begin
      exp_q0.push_back(d);
      expt_q0.push_back(t);
    end else begin
      exp_q1.push_back(d);
      expt_q1.push_back(t);
    end
  endtask

  // Drives a request and holds it until busy is low at the sampling point,
  // so it is taken on the following rising edge.
  task automatic req(int u, logic [3:0] a, logic [7:0] d, logic ws);
    int n = 0;
    @(negedge clk);
    addr[u] = a; wdata[u] = d; wselect[u] = ws; doit[u] = 1'b1;
    while (busy[u] === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("req_timeout", n, 0);
    if (u == 1) chk("lat1_busy_wait", n, 0);
    if (ws) mem_m[u][a] = d;
    else push_exp(u, mem_m[u][a], cyc + 1 + lat_of(u));
  endtask

  task automatic idle(int u);
    @(negedge clk);
    doit[u] = 1'b0;
  endtask

  task automatic sweep(int u);
    int n = 0;
    @(negedge clk);
    init[u] = 1'b0;
    while (busy[u] === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_busy_cycles", n, 16);
    chk("state_idle_after_sweep", int'(dbg[u]), int'(ST_IDLE));
    for (int i = 0; i < 16; i++) mem_m[u][i] = CV;
  endtask

  always @(negedge clk) begin : monitor
    logic [7:0] e;
    int         t;
    logic       have;
    for (int u = 0; u < 2; u++) begin
      if (rvalid[u] === 1'b1) begin
        have = 1'b0;
        e = '0;
        t = 0;
        if (u == 0 && exp_q0.size() > 0) begin
          have = 1'b1; e = exp_q0.pop_front(); t = expt_q0.pop_front();
        end else if (u == 1 && exp_q1.size() > 0) begin
          have = 1'b1; e = exp_q1.pop_front(); t = expt_q1.pop_front();
        end
        if (!have) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_rvalid: dut%0d rdata %0h with no read pending (cycle %0d)", u, rdata[u], cyc);
        end else begin
          chk(u == 0 ? "rdata_dut0" : "rdata_dut1", int'(rdata[u]), int'(e));
          chk(u == 0 ? "rvalid_cycle_dut0" : "rvalid_cycle_dut1", cyc, t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    for (int u = 0; u < 2; u++) begin
      init[u] = 1'b1; addr[u] = '0; wdata[u] = '0; wselect[u] = 1'b0; doit[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_busy", int'(busy[u]), 1);
      chk("reset_rvalid", int'(rvalid[u]), 0);
      chk("reset_rdata", int'(rdata[u]), 0);
      chk("reset_state", int'(dbg[u]), int'(ST_CLEAR));
    end
    sweep(0);
    sweep(1);

    // Every word reads back the clear value.
    for (int a = 0; a < 16; a++) req(0, 4'(a), 8'h00, 1'b0);
    idle(0);
    repeat (5) @(negedge clk);

    // Write then read the same word at the write's completion edge.
    req(0, 4'd7, 8'h3C, 1'b1);
    @(negedge clk);
    doit[0] = 1'b0;
    chk("busy_T+1", int'(busy[0]), 1);
    @(negedge clk);
    chk("busy_T+2", int'(busy[0]), 1);
    req(0, 4'd7, 8'h00, 1'b0);
    idle(0);
    repeat (8) @(negedge clk);

    // doit held for six cycles: only the first and the completion-cycle requests land.
    @(negedge clk);
    c = cyc;
    push_exp(0, mem_m[0][7], c + 4);
    push_exp(0, mem_m[0][7], c + 7);
    addr[0] = 4'd7; wselect[0] = 1'b0; doit[0] = 1'b1;
    repeat (5) @(negedge clk);
    doit[0] = 1'b0;
    repeat (10) @(negedge clk);

    // Reset mid-WAIT drops the pending write.
    @(negedge clk);
    addr[0] = 4'd2; wdata[0] = 8'hFF; wselect[0] = 1'b1; doit[0] = 1'b1;
    @(negedge clk);
    doit[0] = 1'b0;
    init[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midwait_reset_rvalid", int'(rvalid[0]), 0);
    chk("midwait_reset_rdata", int'(rdata[0]), 0);
    sweep(0);
    req(0, 4'd2, 8'h00, 1'b0);
    idle(0);
    repeat (6) @(negedge clk);

    // Reset at sweep address 9 restarts the full sweep.
    @(negedge clk);
    init[0] = 1'b1;
    @(negedge clk);
    init[0] = 1'b0;
    repeat (9) @(negedge clk);
    init[0] = 1'b1;
    chk("midclear_state", int'(dbg[0]), int'(ST_CLEAR));
    chk("midclear_busy", int'(busy[0]), 1);
    sweep(0);
    req(0, 4'd7, 8'h00, 1'b0);
    idle(0);
    repeat (6) @(negedge clk);

    // Latency 1: back-to-back writes then back-to-back reads, no busy.
    for (int a = 0; a < 16; a++) req(1, 4'(a), 8'(a * 7 + 3), 1'b1);
    for (int a = 0; a < 16; a++) req(1, 4'(a), 8'h00, 1'b0);
    idle(1);
    repeat (10) @(negedge clk);

    chk("dut0_pending_reads", exp_q0.size(), 0);
    chk("dut1_pending_reads", exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_sim_latency.md
MEM_SIM_LATENCY -- requirements
Module: mem_sim_latency

Interface
REQ-001 Parameter logsize, default 4: memory depth is 2**logsize words.
REQ-002 Parameter width, default 8: word width in bits.
REQ-003 Parameter latency, default 3: cycles from request acceptance to completion; legal range 1..15.
REQ-004 Parameter clear_value, default 0: value written to every word during the clear sweep.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 init  in  1  reset, asynchronous, active-high.
REQ-007 addr  in  logsize  word address of request.
REQ-008 wdata  in  width  write data.
REQ-009 wselect  in  1  1 = write, 0 = read.
REQ-010 doit  in  1  request strobe.
REQ-011 busy  out  1  1 = request not accepted this cycle.
REQ-012 rvalid  out  1  one-cycle pulse: read completed, rdata valid.
REQ-013 rdata  out  width  data of most recently completed read.

Function
REQ-014 The FSM SHALL have exactly three states: CLEAR, IDLE, WAIT.
REQ-015 CLEAR: one word per cycle written with clear_value, ascending from address 0; after the word at 2**logsize-1 is written, go to IDLE; busy=1 throughout.
REQ-016 A request is accepted at an edge where doit=1 and busy=0; addr, wdata and wselect are captured at that edge.
REQ-017 doit while busy=1 SHALL be ignored, not queued.
REQ-018 Accepted at edge T: the operation completes at edge T+latency; a write updates the array at that edge; a read registers rdata at that edge, and rvalid=1 for the following cycle only.
REQ-019 busy=1 in the latency-1 cycles after acceptance; busy=0 in the completion cycle, so back-to-back requests sustain one operation every latency cycles.
REQ-020 latency=1: busy never asserts in operation; rvalid follows a read request by one cycle.
REQ-021 A write accepted in the same cycle a read completes is legal; the new read sees all writes completed at or before its own completion edge.
REQ-022 rvalid SHALL never pulse for a write; rdata SHALL hold its value until the next read completes.
REQ-023 Latency counter SHALL be 4 bits, load latency-1 on acceptance, decrement to 0, no wrap.
REQ-024 Out-of-range addresses cannot occur (addr is exactly logsize bits); no checking.

Reset
REQ-025 While init=1: state=CLEAR with sweep pointer 0, busy=1, rvalid=0, rdata=0, counter=0.
REQ-026 Sweep starts on the first edge after init deasserts; memory contents are undefined until the sweep completes.
REQ-027 init asserted mid-WAIT drops the pending operation: the write is not applied and rvalid does not pulse.
REQ-028 init asserted mid-CLEAR restarts the sweep from address 0.
REQ-029 Memory array has no reset of its own; it is cleared only by the sweep.

Structure
REQ-030 Shared package mem_sim_pkg SHALL hold the FSM state encoding and the latency counter width constant (4).
REQ-031 Storage SHALL be a sub-module mem_sim_array: one synchronous write port, one asynchronous read port, parameters logsize and width.
REQ-032 FSM, counter, capture registers and the rdata/rvalid registers SHALL reside in mem_sim_latency.

Verification
REQ-033 logsize=4, clear_value=8'h5A: release init, read all 16 words -> busy=1 for 16 cycles after release, then every read returns 8'h5A.
REQ-034 latency=3: write 8'h3C to addr 7 at edge T, read addr 7 at edge T+3 -> busy=1 at T+1 and T+2, rvalid=1 only in the cycle after T+6, rdata=8'h3C.
REQ-035 latency=3: hold doit=1 for 6 cycles during WAIT -> only the first and the completion-cycle requests are accepted, and no extra rvalid pulses occur.
REQ-036 latency=1: stream reads of addr 0..15 back-to-back -> busy stays 0, one rvalid per read, in order, one cycle after each request.
REQ-037 Write 8'hFF to addr 2, assert init one cycle later (mid-WAIT), release -> no rvalid, and after the sweep addr 2 reads clear_value.
REQ-038 Assert init at sweep address 9, release -> the sweep restarts at 0, and busy stays high for 16 more cycles.
